// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter with minimum hold time that shares a 4-digit seven-segment driver.
// Optional urgent preemption by requester 0 is enabled with `define SEG_ARB_PREEMPT_EN.
module seg_display_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter logic [15:0] IDLE_VAL    = 16'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  val_bus,
    input  logic [NUM_REQ-1:0]     alt_bus,
    output logic [NUM_REQ-1:0]     grant,
    output logic [2:0]             owner_id,
    output logic [15:0]            disp_val,
    output logic                   disp_alt,
    output logic                   disp_valid
);

    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [15:0] SAT_MAX = 16'd9999;

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ID_W-1:0]    last, last_n, owner_n, win;
    logic [NUM_REQ-1:0] grant_n, cand, req_sh;
    logic [15:0]        val_n;
    logic               alt_n, valid_n, take, owner_req;

    // First requester in cand after 'from', wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                                input logic [ID_W-1:0] from);
        logic [NUM_REQ-1:0] sh;
        int unsigned        idx;
        logic               found;
        rr_pick = from;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(from) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sh = c >> idx;
            if (!found && sh[0]) begin
                found   = 1'b1;
                rr_pick = ID_W'(idx);
            end
        end
    endfunction

    // The driver shows four decimal digits, so larger values clamp to 9999.
    function automatic logic [15:0] pick_val(input logic [16*NUM_REQ-1:0] bus,
                                             input logic [ID_W-1:0] i);
        logic [16*NUM_REQ-1:0] sh;
        sh = bus >> (32'(i) * 32'd16);
        return (sh[15:0] > SAT_MAX) ? SAT_MAX : sh[15:0];
    endfunction

    function automatic logic pick_alt(input logic [NUM_REQ-1:0] bus,
                                      input logic [ID_W-1:0] i);
        logic [NUM_REQ-1:0] sh;
        sh = bus >> i;
        return sh[0];
    endfunction

`ifdef SEG_ARB_PREEMPT_EN
    logic req0_q;

    always_ff @(posedge clk) begin
        if (reset) req0_q <= 1'b0;
        else       req0_q <= req[0];
    end
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        owner_n = owner_id;
        valid_n = disp_valid;
        val_n   = disp_val;
        alt_n   = disp_alt;
        take    = 1'b0;
        // The current owner may not re-win once its hold has expired.
        cand      = req & ~((state == OPEN) ? grant : '0);
        win       = rr_pick(cand, last);
        req_sh    = req >> owner_id;
        owner_req = req_sh[0];

        case (state)
            IDLE: take = |req;
            HOLD: begin
                if (cnt == '0) state_n = OPEN;
                else           cnt_n   = cnt - CNT_W'(1);
                if (owner_req) begin
                    val_n = pick_val(val_bus, owner_id);
                    alt_n = pick_alt(alt_bus, owner_id);
                end
            end
            OPEN: begin
                if (|cand) begin
                    take = 1'b1;
                end else if (owner_req) begin
                    val_n = pick_val(val_bus, owner_id);
                    alt_n = pick_alt(alt_bus, owner_id);
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    owner_n = '0;
                    valid_n = 1'b0;
                    val_n   = IDLE_VAL;
                    alt_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef SEG_ARB_PREEMPT_EN
        if (state != IDLE && owner_id != '0 && req[0] && !req0_q) begin
            take = 1'b1;
            win  = '0;
        end
`endif

        if (take) begin
            state_n = HOLD;
            cnt_n   = HOLD_LOAD;
            last_n  = win;
            owner_n = win;
            valid_n = 1'b1;
            val_n   = pick_val(val_bus, win);
            alt_n   = pick_alt(alt_bus, win);
        end

        grant_n = valid_n ? (NUM_REQ'(1) << owner_n) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= ID_W'(NUM_REQ - 1);
            grant      <= '0;
            owner_id   <= '0;
            disp_val   <= IDLE_VAL;
            disp_alt   <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last       <= last_n;
            grant      <= grant_n;
            owner_id   <= owner_n;
            disp_val   <= val_n;
            disp_alt   <= alt_n;
            disp_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus randomized traffic checked
// against an age-based ownership model (HOLD_CYCLES=4, NUM_REQ=3).
module tb_seg_display_arbiter;

    localparam int H = 4;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [47:0] val_bus;
    logic [2:0]  alt_bus;
    logic [2:0]  grant;
    logic [2:0]  owner_id;
    logic [15:0] disp_val;
    logic        disp_alt;
    logic        disp_valid;

    int tests = 0;
    int fails = 0;

    // Model: owner (-1 idle), edges since grant, round-robin pointer, shown data.
    int          m_owner = -1;
    int          m_age   = 0;
    int          m_last  = 2;
    logic [15:0] m_val   = 16'd0;
    logic        m_alt   = 1'b0;

    seg_display_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(H), .IDLE_VAL(16'd0)) dut (
        .clk(clk), .reset(reset), .req(req), .val_bus(val_bus), .alt_bus(alt_bus),
        .grant(grant), .owner_id(owner_id), .disp_val(disp_val),
        .disp_alt(disp_alt), .disp_valid(disp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [2:0] c, input int from);
        for (int k = 1; k <= 3; k++) begin
            if (c[(from + k) % 3]) return (from + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v > 16'd9999) ? 16'd9999 : v;
    endfunction

    task automatic show(input int o);
        m_val = sat(val_bus[16*o +: 16]);
        m_alt = alt_bus[o];
    endtask

    task automatic give(input int o);
        m_owner = o;
        m_last  = o;
        m_age   = 0;
        show(o);
    endtask

    // Apply this cycle's inputs to the model: owner is locked for H edges after a grant.
    task automatic model_edge();
        logic [2:0] c;
        if (reset) begin
            m_owner = -1; m_last = 2; m_val = 16'd0; m_alt = 1'b0;
        end else if (m_owner < 0) begin
            if (req != 3'b000) give(rr(req, m_last));
        end else if (m_age < H) begin
            m_age++;
            if (req[m_owner]) show(m_owner);
        end else begin
            c = req;
            c[m_owner] = 1'b0;
            if (c != 3'b000) give(rr(c, m_last));
            else if (req[m_owner]) begin
                show(m_owner);
                m_age++;
            end else begin
                m_owner = -1; m_val = 16'd0; m_alt = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [2:0] eg;
        model_edge();
        @(posedge clk);
        #1;
        eg = 3'b000;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("grant", 32'(grant), 32'(eg));
        chk("owner_id", 32'(owner_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk("disp_valid", 32'(disp_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("disp_val", 32'(disp_val), 32'(m_val));
        chk("disp_alt", 32'(disp_alt), 32'(m_alt));
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 3'b000;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 3'b000; val_bus = '0; alt_bus = 3'b000;

        // Reset state, then idle with no requests.
        do_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_val", 32'(disp_val), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", 32'(disp_valid), 32'd0);
        end

        // Single requester 1 with alternate format.
        val_bus[31:16] = 16'd1234; alt_bus = 3'b010; req = 3'b010;
        tick();
        chk("r1_grant", 32'(grant), 32'b010);
        chk("r1_id", 32'(owner_id), 32'd1);
        chk("r1_val", 32'(disp_val), 32'd1234);
        chk("r1_alt", 32'(disp_alt), 32'd1);

        // All three requesting: 0,1,2,0 each for 4 hold cycles + 1 open cycle.
        do_reset();
        alt_bus = 3'b000; val_bus = {16'd300, 16'd200, 16'd100}; req = 3'b111;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("rr_seq", 32'(owner_id), 32'((i / 5) % 3));
        end

        // Owner 0 drops req during hold: grant and value freeze, then idle.
        do_reset();
        val_bus[15:0] = 16'd42; req = 3'b001;
        tick();
        tick();
        req = 3'b000; val_bus[15:0] = 16'd77;
        for (int i = 2; i < 5; i++) begin
            tick();
            chk("drop_grant", 32'(grant), 32'b001);
            chk("drop_val", 32'(disp_val), 32'd42);
        end
        tick();
        chk("drop_idle_grant", 32'(grant), 32'd0);
        chk("drop_idle_val", 32'(disp_val), 32'd0);

        // Saturation boundaries.
        do_reset();
        val_bus[15:0] = 16'd12000; req = 3'b001;
        tick();
        chk("sat_12000", 32'(disp_val), 32'd9999);
        val_bus[15:0] = 16'd9999;
        tick();
        chk("sat_9999", 32'(disp_val), 32'd9999);
        val_bus[15:0] = 16'd0;
        tick();
        chk("sat_0", 32'(disp_val), 32'd0);

        // Reset pulse in the middle of a hold.
        do_reset();
        req = 3'b100;
        tick();
        tick();
        chk("pre_rst_grant", 32'(grant), 32'b100);
        reset = 1'b1;
        tick();
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_valid", 32'(disp_valid), 32'd0);
        reset = 1'b0;

        // req[0] rising during requester 2's hold waits for the hold to finish.
        do_reset();
        req = 3'b100;
        tick();
        tick();
        req = 3'b101;
        for (int i = 2; i < 5; i++) begin
            tick();
            chk("nopre_hold", 32'(owner_id), 32'd2);
        end
        tick();
        chk("nopre_switch", 32'(grant), 32'b001);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) req = 3'($urandom_range(0, 7));
            for (int j = 0; j < 3; j++) begin
                val_bus[16*j +: 16] = 16'($urandom_range(0, 16000));
                alt_bus[j] = 1'($urandom_range(0, 1));
            end
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the 4-digit seven-segment display driver between NUM_REQ requesters, such as a score counter, a timer and a status/message source. It arbitrates with a round-robin policy and a guaranteed minimum on-screen hold time. It then drives the driver's 16-bit binary value input and its alternate-format select from the winning requester. The block sits directly upstream of the display driver, and all outputs are registered.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
HOLD_CYCLES, 100000000, minimum clk cycles a granted requester stays on screen (>=1)
IDLE_VAL, 16'd0, value driven on disp_val when no owner

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester display request, level-sensitive
val_bus  input  16*NUM_REQ  packed binary values; requester i uses bits [16i+15:16i]
alt_bus  input  NUM_REQ  per-requester alternate-format select
grant  output  NUM_REQ  one-hot current owner; all zero when idle
owner_id  output  3  index of current owner; 0 when idle
disp_val  output  16  value to the display driver, saturated to 9999
disp_alt  output  1  alternate-format select to the display driver
disp_valid  output  1  high while an owner holds the display

Behaviour:
- One clock (clk). reset is synchronous and active-high.
- All state and outputs update on posedge clk only.
- Reset values:
  - grant=0, owner_id=0, disp_val=IDLE_VAL, disp_alt=0, disp_valid=0.
  - FSM state=IDLE, hold counter=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-operation drops the grant on the next edge, with no partial hold.
- Round-robin pick:
  - Search indices last+1, last+2, … (mod NUM_REQ) and take the first with req high.
  - The current owner is excluded from the search in OPEN.
  - On every new grant, last := the winner.
- FSM state IDLE:
  - If any req is high, grant the RR winner and go to HOLD.
  - Load the hold counter with HOLD_CYCLES-1.
- FSM state HOLD:
  - The owner keeps the grant regardless of its req.
  - The counter decrements each cycle; when counter==0, go to OPEN on the next edge.
- FSM state OPEN:
  - If a non-owner req is high, grant the RR winner among non-owners, go to HOLD and reload the counter.
  - Else, if the owner's req is high, stay in OPEN.
  - Else, go to IDLE; grant=0, disp_valid=0, disp_val=IDLE_VAL, disp_alt=0.
- Latency:
  - req sampled high in IDLE at edge N gives grant, owner_id and disp_valid at edge N+1.
  - disp_val and disp_alt at edge N+1 reflect the owner's val and alt sampled at edge N.
  - On a switch, the new owner's value appears on the same edge the grant moves.
- Data tracking:
  - While the owner's req is high, disp_val/disp_alt follow the owner's inputs with 1-cycle latency.
  - If the owner drops req during HOLD, disp_val/disp_alt freeze at the last value captured while req was high.
- Saturation:
  - Any captured value >9999 is driven as 16'd9999, because the driver shows 4 decimal digits.
  - Values <=9999 pass unchanged.
- Simultaneous requests: resolved purely by the RR order from last. No fixed priority unless the optional feature is enabled.
- grant is always one-hot or zero. owner_id always matches grant.

Optional Feature:
- Macro: SEG_ARB_PREEMPT_EN.
- Defined:
  - Requester 0 is urgent.
  - If req[0] rises while another requester owns the display, in HOLD or OPEN, requester 0 is granted on the next edge.
  - The hold counter reloads with HOLD_CYCLES-1 and last := 0.
  - Requester 0 itself is never preempted.
- Undefined: requester 0 is ordinary round-robin with no preemption logic, and the hold time is always honoured.

Test Plan (benches run with HOLD_CYCLES=4, NUM_REQ=3):
- Reset released, req=3'b000 for 10 cycles -> grant=0, disp_valid=0, disp_val=0 throughout.
- req=3'b010, val1=1234, alt1=1 at edge N -> at N+1 grant=3'b010, owner_id=1, disp_val=1234, disp_alt=1, disp_valid=1.
- req=3'b111 held continuously -> ownership sequence 0,1,2,0, with each owner granted for exactly 4 cycles, plus 1 OPEN cycle, before the switch.
- Owner 0 (val0=42) drops req one cycle into HOLD, with no other requesters:
  - grant stays 3'b001 and disp_val stays 42 until HOLD expires.
  - The block then passes through OPEN and reaches IDLE with disp_val=0.
- Owner val=16'd12000 -> disp_val=9999. Owner val=9999 -> disp_val=9999. Owner val=0 -> disp_val=0.
- Requester 2 mid-HOLD, reset pulsed for 1 cycle -> next edge: grant=0, disp_valid=0.
- With SEG_ARB_PREEMPT_EN defined, requester 2 mid-HOLD and req[0] rises at edge N -> grant=3'b001 at N+1, new 4-cycle hold.
- Without SEG_ARB_PREEMPT_EN, same stimulus -> requester 2 finishes its hold and requester 0 is granted after it.
